// File: rtl/alu_op_sequencer.sv
// Micro-sequencer that walks the register datapath through load-Y, execute and write-back for one ALU op.
// Define SEQ_IMM_EN to add the imm_sel port and the memory-operand (LOAD_MDR) step.
module alu_op_sequencer #(
  parameter int              NUM_REGS = 16,
  parameter int              IDX_W    = 4,
  parameter int              OP_W     = 5,
  parameter logic [OP_W-1:0] OP_MUL   = OP_W'(5'b01110),
  parameter logic [OP_W-1:0] OP_DIV   = OP_W'(5'b01111)
) (
  input  logic                clock,
  input  logic                clear,
  input  logic                start,
  input  logic [OP_W-1:0]     op,
  input  logic [IDX_W-1:0]    ra_idx,
  input  logic [IDX_W-1:0]    rb_idx,
  input  logic [IDX_W-1:0]    rc_idx,
`ifdef SEQ_IMM_EN
  input  logic                imm_sel,
`endif
  output logic                busy,
  output logic                done,
  output logic                bad_idx,
  output logic [OP_W-1:0]     alu_op,
  output logic [NUM_REGS-1:0] reg_out,
  output logic [NUM_REGS-1:0] reg_in,
  output logic                ry_in,
  output logic                rz_in,
  output logic                rzlo_out,
  output logic                rzhi_out,
  output logic                hi_in,
  output logic                lo_in,
  output logic                mdr_in,
  output logic                mdr_out,
  output logic                read
);

  typedef enum logic [2:0] {
    IDLE,
`ifdef SEQ_IMM_EN
    LOAD_MDR,
`endif
    LOAD_Y,
    EXEC,
    WB_LO,
    WB_HI,
    DONE
  } state_t;

  state_t           state, state_nxt;
  logic [OP_W-1:0]  op_q, op_nxt;
  logic [IDX_W-1:0] ra_q, rb_q, rc_q, ra_nxt, rb_nxt, rc_nxt;
  logic             imm_nxt, muldiv_nxt, bad_nxt;
`ifdef SEQ_IMM_EN
  logic             imm_q;
`endif

  // Out-of-range indices simply produce an all-zero enable bus.
  function automatic logic [NUM_REGS-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REGS-1:0] oh;
    oh = '0;
    for (int i = 0; i < NUM_REGS; i++) oh[i] = (int'(idx) == i);
    return oh;
  endfunction

  function automatic logic in_range(input logic [IDX_W-1:0] idx);
    return int'(idx) < NUM_REGS;
  endfunction

  // Next state plus the operand fields that will be held in that state, so outputs can be registered.
  always_comb begin
    state_nxt = state;
    op_nxt    = op_q;
    ra_nxt    = ra_q;
    rb_nxt    = rb_q;
    rc_nxt    = rc_q;
`ifdef SEQ_IMM_EN
    imm_nxt   = imm_q;
`else
    imm_nxt   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (start) begin
          op_nxt    = op;
          ra_nxt    = ra_idx;
          rb_nxt    = rb_idx;
          rc_nxt    = rc_idx;
`ifdef SEQ_IMM_EN
          imm_nxt   = imm_sel;
          state_nxt = imm_sel ? LOAD_MDR : LOAD_Y;
`else
          state_nxt = LOAD_Y;
`endif
        end
      end
`ifdef SEQ_IMM_EN
      LOAD_MDR: state_nxt = LOAD_Y;
`endif
      LOAD_Y:   state_nxt = EXEC;
      EXEC:     state_nxt = WB_LO;
      WB_LO:    state_nxt = (op_q == OP_MUL || op_q == OP_DIV) ? WB_HI : DONE;
      WB_HI:    state_nxt = DONE;
      DONE:     state_nxt = IDLE;
      default:  state_nxt = IDLE;
    endcase
    muldiv_nxt = (op_nxt == OP_MUL) || (op_nxt == OP_DIV);
    bad_nxt    = (!imm_nxt && !in_range(ra_nxt)) || !in_range(rb_nxt) ||
                 (!muldiv_nxt && !in_range(rc_nxt));
  end

  // Strobes are decoded from the state being entered, so each is high exactly while in that state.
  always_ff @(posedge clock) begin
    if (clear) begin
      state    <= IDLE;
      op_q     <= '0;
      ra_q     <= '0;
      rb_q     <= '0;
      rc_q     <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      bad_idx  <= 1'b0;
      alu_op   <= '0;
      reg_out  <= '0;
      reg_in   <= '0;
      ry_in    <= 1'b0;
      rz_in    <= 1'b0;
      rzlo_out <= 1'b0;
      rzhi_out <= 1'b0;
      hi_in    <= 1'b0;
      lo_in    <= 1'b0;
    end else begin
      state    <= state_nxt;
      op_q     <= op_nxt;
      ra_q     <= ra_nxt;
      rb_q     <= rb_nxt;
      rc_q     <= rc_nxt;
      busy     <= state_nxt != IDLE;
      done     <= state_nxt == DONE;
      bad_idx  <= (state_nxt == DONE) && bad_nxt;
      alu_op   <= (state_nxt == EXEC) ? op_nxt : '0;
      reg_out  <= (state_nxt == LOAD_Y && !imm_nxt) ? onehot(ra_nxt) :
                  (state_nxt == EXEC) ? onehot(rb_nxt) : '0;
      reg_in   <= (state_nxt == WB_LO && !muldiv_nxt) ? onehot(rc_nxt) : '0;
      ry_in    <= state_nxt == LOAD_Y;
      rz_in    <= state_nxt == EXEC;
      rzlo_out <= state_nxt == WB_LO;
      lo_in    <= (state_nxt == WB_LO) && muldiv_nxt;
      rzhi_out <= state_nxt == WB_HI;
      hi_in    <= state_nxt == WB_HI;
    end
  end

`ifdef SEQ_IMM_EN
  always_ff @(posedge clock) begin
    if (clear) begin
      imm_q   <= 1'b0;
      mdr_in  <= 1'b0;
      mdr_out <= 1'b0;
      read    <= 1'b0;
    end else begin
      imm_q   <= imm_nxt;
      mdr_in  <= state_nxt == LOAD_MDR;
      read    <= state_nxt == LOAD_MDR;
      mdr_out <= (state_nxt == LOAD_Y) && imm_nxt;
    end
  end
`else
  assign mdr_in  = 1'b0;
  assign mdr_out = 1'b0;
  assign read    = 1'b0;
`endif

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Randomized self-checking bench for alu_op_sequencer: a 16-register and an 8-register instance share stimulus
// and are compared cycle by cycle against a per-step output table built from the sequencing rules.
module tb_alu_op_sequencer;

  localparam logic [4:0] MUL = 5'b01110;
  localparam logic [4:0] DIV = 5'b01111;

  logic clock = 1'b0;
  logic clear, start;
  logic [4:0] op;
  logic [3:0] raIdx, rbIdx, rcIdx;
`ifdef SEQ_IMM_EN
  logic immSel;
`endif

  logic a_busy, a_done, a_bad, a_ry, a_rz, a_rzlo, a_rzhi, a_hi, a_lo, a_mi, a_mo, a_rd;
  logic [4:0] a_alu;
  logic [15:0] a_rout, a_rin;
  logic b_busy, b_done, b_bad, b_ry, b_rz, b_rzlo, b_rzhi, b_hi, b_lo, b_mi, b_mo, b_rd;
  logic [4:0] b_alu;
  logic [7:0] b_rout, b_rin;

  int checkCount = 0;
  int errCount = 0;

  always #5 clock = ~clock;

  alu_op_sequencer #(.NUM_REGS(16)) dutA (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .ra_idx(raIdx), .rb_idx(rbIdx), .rc_idx(rcIdx),
`ifdef SEQ_IMM_EN
    .imm_sel(immSel),
`endif
    .busy(a_busy), .done(a_done), .bad_idx(a_bad), .alu_op(a_alu),
    .reg_out(a_rout), .reg_in(a_rin), .ry_in(a_ry), .rz_in(a_rz),
    .rzlo_out(a_rzlo), .rzhi_out(a_rzhi), .hi_in(a_hi), .lo_in(a_lo),
    .mdr_in(a_mi), .mdr_out(a_mo), .read(a_rd));

  alu_op_sequencer #(.NUM_REGS(8)) dutB (
    .clock(clock), .clear(clear), .start(start), .op(op),
    .ra_idx(raIdx), .rb_idx(rbIdx), .rc_idx(rcIdx),
`ifdef SEQ_IMM_EN
    .imm_sel(immSel),
`endif
    .busy(b_busy), .done(b_done), .bad_idx(b_bad), .alu_op(b_alu),
    .reg_out(b_rout), .reg_in(b_rin), .ry_in(b_ry), .rz_in(b_rz),
    .rzlo_out(b_rzlo), .rzhi_out(b_rzhi), .hi_in(b_hi), .lo_in(b_lo),
    .mdr_in(b_mi), .mdr_out(b_mo), .read(b_rd));

  // Packed layout: {busy,done,bad,alu_op[5],reg_out[16],reg_in[16],ry,rz,rzlo,rzhi,hi,lo,mdr_in,mdr_out,read}
  function automatic logic [63:0] obsA();
    return {15'd0, a_busy, a_done, a_bad, a_alu, a_rout, a_rin,
            a_ry, a_rz, a_rzlo, a_rzhi, a_hi, a_lo, a_mi, a_mo, a_rd};
  endfunction

  function automatic logic [63:0] obsB();
    return {15'd0, b_busy, b_done, b_bad, b_alu, 8'd0, b_rout, 8'd0, b_rin,
            b_ry, b_rz, b_rzlo, b_rzhi, b_hi, b_lo, b_mi, b_mo, b_rd};
  endfunction

  // Reference: phase -1 idle, 0 memory read, 1 load Y, 2 execute, 3 low write-back, 4 high write-back, 5 done.
  function automatic logic [63:0] expVec(int phase, int n, logic [4:0] o, int a, int b, int c, bit imm);
    bit md, bsy, dn, bd, ry, rz, zlo, zhi, hi, lo, mi, mo, rd;
    logic [4:0] alu;
    logic [15:0] ro, ri;
    md = (o == MUL) || (o == DIV);
    {dn, bd, ry, rz, zlo, zhi, hi, lo, mi, mo, rd} = '0;
    alu = '0; ro = '0; ri = '0;
    bsy = phase >= 0;
    case (phase)
      0: begin rd = 1; mi = 1; end
      1: begin ry = 1; if (imm) mo = 1; else if (a < n) ro = 16'(1 << a); end
      2: begin rz = 1; alu = o; if (b < n) ro = 16'(1 << b); end
      3: begin zlo = 1; if (md) lo = 1; else if (c < n) ri = 16'(1 << c); end
      4: begin zhi = 1; hi = 1; end
      5: begin dn = 1; bd = (!imm && a >= n) || b >= n || (!md && c >= n); end
      default: ;
    endcase
    return {15'd0, bsy, dn, bd, alu, ro, ri, ry, rz, zlo, zhi, hi, lo, mi, mo, rd};
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errCount++;
      $display("[TB] FAIL %s got=%h want=%h", tag, obs, exp);
    end
  endtask

  task automatic driveNoise(input bit noise, input logic [4:0] noiseOp);
    start = noise;
    op = noiseOp;
    raIdx = 4'($urandom_range(15));
    rbIdx = 4'($urandom_range(15));
    rcIdx = 4'($urandom_range(15));
`ifdef SEQ_IMM_EN
    immSel = 1'($urandom_range(1));
`endif
  endtask

  task automatic idleCycles(input int n);
    start = 1'b0;
    repeat (n) begin
      @(negedge clock);
      checkOutput("idle16", obsA(), expVec(-1, 16, 0, 0, 0, 0, 0));
      checkOutput("idle8", obsB(), expVec(-1, 8, 0, 0, 0, 0, 0));
      @(posedge clock); #1;
    end
  endtask

  // One full transaction; with noise, start is re-asserted with other fields while busy and must be ignored.
  task automatic applyStimulus(input logic [4:0] o, input int a, input int b, input int c,
                               input bit imm, input bit noise, input logic [4:0] noiseOp);
    int phases[$];
    if (imm) phases.push_back(0);
    phases.push_back(1); phases.push_back(2); phases.push_back(3);
    if (o == MUL || o == DIV) phases.push_back(4);
    phases.push_back(5);
    start = 1'b1; op = o; raIdx = 4'(a); rbIdx = 4'(b); rcIdx = 4'(c);
`ifdef SEQ_IMM_EN
    immSel = imm;
`endif
    @(negedge clock);
    checkOutput("preaccept16", obsA(), expVec(-1, 16, 0, 0, 0, 0, 0));
    @(posedge clock); #1;
    driveNoise(noise, noiseOp);
    foreach (phases[k]) begin
      @(negedge clock);
      checkOutput($sformatf("ph%0d_16", phases[k]), obsA(), expVec(phases[k], 16, o, a, b, c, imm));
      checkOutput($sformatf("ph%0d_8", phases[k]), obsB(), expVec(phases[k], 8, o, a, b, c, imm));
      @(posedge clock); #1;
      if (k == phases.size() - 1) start = 1'b0;
      else driveNoise(noise, noiseOp);
    end
  endtask

  // Clear during EXEC, with start also high, must drop straight to idle and never raise done.
  task automatic abortTxn(input logic [4:0] o, input int a, input int b, input int c);
    start = 1'b1; op = o; raIdx = 4'(a); rbIdx = 4'(b); rcIdx = 4'(c);
`ifdef SEQ_IMM_EN
    immSel = 1'b0;
`endif
    @(posedge clock); #1;
    start = 1'b0;
    @(negedge clock);
    checkOutput("abortLY", obsA(), expVec(1, 16, o, a, b, c, 0));
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("abortEX", obsA(), expVec(2, 16, o, a, b, c, 0));
    clear = 1'b1; start = 1'b1;
    @(posedge clock); #1;
    @(negedge clock);
    checkOutput("abortIdle16", obsA(), expVec(-1, 16, 0, 0, 0, 0, 0));
    checkOutput("abortIdle8", obsB(), expVec(-1, 8, 0, 0, 0, 0, 0));
    @(posedge clock); #1;
    clear = 1'b0;
    idleCycles(3);
  endtask

  initial begin
    clear = 1'b1; start = 1'b1; op = 5'b00101; raIdx = 4'd2; rbIdx = 4'd3; rcIdx = 4'd1;
`ifdef SEQ_IMM_EN
    immSel = 1'b0;
`endif
    repeat (2) begin
      @(posedge clock); #1;
      @(negedge clock);
      checkOutput("reset16", obsA(), expVec(-1, 16, 0, 0, 0, 0, 0));
      checkOutput("reset8", obsB(), expVec(-1, 8, 0, 0, 0, 0, 0));
    end
    @(posedge clock); #1;
    clear = 1'b0;
    idleCycles(1);

    applyStimulus(5'b00101, 2, 3, 1, 0, 0, 5'd0);
    applyStimulus(MUL, 4, 5, 6, 0, 0, 5'd0);
    applyStimulus(DIV, 7, 12, 9, 0, 0, 5'd0);
    applyStimulus(5'b01010, 6, 1, 2, 0, 1, 5'b00011);
    applyStimulus(5'b00001, 0, 15, 3, 0, 0, 5'd0);
    abortTxn(5'b00110, 1, 2, 3);
    applyStimulus(5'b00101, 1, 9, 2, 0, 0, 5'd0);
    applyStimulus(MUL, 3, 4, 13, 0, 0, 5'd0);
`ifdef SEQ_IMM_EN
    applyStimulus(5'b00100, 10, 2, 5, 1, 0, 5'd0);
    applyStimulus(DIV, 9, 3, 1, 1, 1, 5'b00011);
`endif

    for (int t = 0; t < 40; t++) begin
      logic [4:0] o;
      bit imm;
      case ($urandom_range(3))
        0: o = MUL;
        1: o = DIV;
        default: o = 5'($urandom_range(31));
      endcase
      imm = 1'b0;
`ifdef SEQ_IMM_EN
      imm = 1'($urandom_range(1));
`endif
      applyStimulus(o, $urandom_range(15), $urandom_range(15), $urandom_range(15),
                    imm, 1'($urandom_range(1)), 5'($urandom_range(31)));
      idleCycles($urandom_range(2));
    end

    $display("test done: total=%0d bad=%0d", checkCount, errCount);
    $finish;
  end

endmodule
